// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed driver for an N-digit common-anode 7-segment
//                display. Holds a loadable digit/decimal-point register, scans
//                one digit per refresh slot (with one dead-time cycle at the
//                start of every slot), and decodes the active nibble to
//                active-low segments with optional hex glyphs and
//                leading-zero blanking.
//
//  Ports       : clk        in   system clock, rising edge
//                rst        in   synchronous active-high reset
//                load       in   capture value/dp_in on this edge
//                value      in   packed nibbles, digit 0 = value[3:0] (rightmost)
//                dp_in      in   decimal-point request per digit, 1 = lit
//                enable     in   0 forces all anodes off, scan keeps running
//                an         out  anode enables, active-low
//                seg        out  segments {g,f,e,d,c,b,a}, active-low
//                dp         out  decimal point, active-low
//                frame_done out  one-cycle pulse per completed scan frame
//
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter bit HEX_EN      = 1'b0,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    enable,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int C_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int C_CNT_W = $clog2(REFRESH_DIV);

    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(NUM_DIGITS - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]         C_SEG_OFF  = 7'h7F;

    // ------------------------------------------------------------------
    // Scan and display state
    // ------------------------------------------------------------------
    logic [C_CNT_W-1:0]      r_cnt;
    logic [C_IDX_W-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [NUM_DIGITS-1:0]   r_dpr;

    // Registered outputs
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_done;

    // Combinational view of the current slot
    logic [3:0]              w_nib;
    logic                    w_dp_bit;
    logic                    w_upper_nz;
    logic [NUM_DIGITS-1:0]   w_an;
    logic                    w_dark;
    logic                    w_blank;
    logic                    w_slot_end;
    logic                    w_frame_end;

    // Active-low glyph table; nibbles 10-15 are only reached with hex enabled.
    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    assign w_slot_end  = (r_cnt == C_CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == C_IDX_LAST);

    // Select the active digit, and find whether anything non-zero sits at or
    // above it (used for leading-zero blanking).
    always_comb begin
        w_nib      = 4'd0;
        w_dp_bit   = 1'b0;
        w_upper_nz = 1'b0;
        w_dark     = (r_cnt == '0) || !enable;
        w_an       = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (C_IDX_W'(i) == r_idx) begin
                w_nib    = r_disp[4*i +: 4];
                w_dp_bit = r_dpr[i];
                w_an[i]  = w_dark;
            end
            if ((C_IDX_W'(i) >= r_idx) && (r_disp[4*i +: 4] != 4'd0)) begin
                w_upper_nz = 1'b1;
            end
        end
    end

    // Digit 0 is never a leading zero, so a zero value still shows "0".
    always_comb begin
        w_blank = 1'b0;
        if (LZ_BLANK && (r_idx != '0) && !w_upper_nz) begin
            w_blank = 1'b1;
        end
        if (!HEX_EN && (w_nib > 4'd9)) begin
            w_blank = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scan counters and display register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_disp <= '0;
            r_dpr  <= '0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + C_IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + C_CNT_W'(1);
            end
            // A load lands immediately; since outputs are computed from the
            // registered state, a simultaneous slot change and load are both
            // visible together one cycle later.
            if (load) begin
                r_disp <= value;
                r_dpr  <= dp_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an         <= '1;
            r_seg        <= C_SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_blank ? C_SEG_OFF : f_glyph(w_nib);
            r_dp         <= w_dark ? 1'b1 : ~w_dp_bit;
            r_frame_done <= w_frame_end;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
